// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register with load alignment and register-file write port
module mem_wb_stage #(
  parameter int width     = 32,
  parameter int AddrWidth = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 mem_valid,
  input  logic                 mem_reg_write,
  input  logic [AddrWidth-1:0] mem_write_reg,
  input  logic [width-1:0]     mem_alu_result,
  input  logic [2:0]           mem_load_type,
  input  logic [1:0]           mem_addr_lo,
  input  logic [width-1:0]     mem_rdata,
  input  logic [width-1:0]     mem_rt_value,
  output logic                 wb_valid,
  output logic                 RegWrite,
  output logic [AddrWidth-1:0] Write_register,
  output logic [width-1:0]     Write_data
);
  logic                 committed;
  logic                 reg_write_q;
  logic [AddrWidth-1:0] write_reg_q;
  logic [width-1:0]     alu_q, rdata_q, rt_q;
  logic [2:0]           load_type_q;
  logic [1:0]           addr_lo_q;
  logic [7:0]           b;
  logic [15:0]          h;
  logic [width-1:0]     lwl, lwr, data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid    <= 1'b0;
      committed   <= 1'b0;
      reg_write_q <= 1'b0;
      write_reg_q <= '0;
      alu_q       <= '0;
      rdata_q     <= '0;
      rt_q        <= '0;
      load_type_q <= '0;
      addr_lo_q   <= '0;
    end else if (flush) begin
      wb_valid  <= 1'b0;
      committed <= 1'b0;
    end else if (stall) begin
      committed <= committed | RegWrite;
    end else begin
      wb_valid    <= mem_valid;
      committed   <= 1'b0;
      reg_write_q <= mem_reg_write;
      write_reg_q <= mem_write_reg;
      alu_q       <= mem_alu_result;
      rdata_q     <= mem_rdata;
      rt_q        <= mem_rt_value;
      load_type_q <= mem_load_type;
      addr_lo_q   <= mem_addr_lo;
    end
  end
  // A held instruction writes once; committed masks the remaining stall cycles
  assign RegWrite       = wb_valid & reg_write_q & (|write_reg_q) & ~committed;
  assign Write_register = wb_valid ? write_reg_q : '0;
  assign b = rdata_q[{addr_lo_q, 3'b000} +: 8];
  assign h = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
  assign lwl = addr_lo_q == 2'd0 ? {rdata_q[7:0],  rt_q[23:0]} :
               addr_lo_q == 2'd1 ? {rdata_q[15:0], rt_q[15:0]} :
               addr_lo_q == 2'd2 ? {rdata_q[23:0], rt_q[7:0]}  : rdata_q;
  assign lwr = addr_lo_q == 2'd0 ? rdata_q :
               addr_lo_q == 2'd1 ? {rt_q[31:24], rdata_q[31:8]}  :
               addr_lo_q == 2'd2 ? {rt_q[31:16], rdata_q[31:16]} : {rt_q[31:8], rdata_q[31:24]};
  always_comb begin
    data = alu_q;
    case (load_type_q)
      3'd1:    data = {{24{b[7]}}, b};
      3'd2:    data = {24'd0, b};
      3'd3:    data = {{16{h[15]}}, h};
      3'd4:    data = {16'd0, h};
      3'd5:    data = rdata_q;
      3'd6:    data = lwl;
      3'd7:    data = lwr;
      default: data = alu_q;
    endcase
  end
  assign Write_data = wb_valid ? data : '0;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0;
  logic        mem_valid = 1'b0, mem_reg_write = 1'b0;
  logic [4:0]  mem_write_reg = '0;
  logic [31:0] mem_alu_result = '0, mem_rdata = '0, mem_rt_value = '0;
  logic [2:0]  mem_load_type = '0;
  logic [1:0]  mem_addr_lo = '0;
  logic        wb_valid, RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  int checks = 0, failures = 0;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
    .mem_alu_result(mem_alu_result), .mem_load_type(mem_load_type), .mem_addr_lo(mem_addr_lo),
    .mem_rdata(mem_rdata), .mem_rt_value(mem_rt_value),
    .wb_valid(wb_valid), .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic rw, input logic [4:0] dst, input logic [31:0] alu,
                       input logic [2:0] lt, input logic [1:0] a, input logic [31:0] rd, input logic [31:0] rt);
    @(negedge clk);
    mem_valid = v; mem_reg_write = rw; mem_write_reg = dst; mem_alu_result = alu;
    mem_load_type = lt; mem_addr_lo = a; mem_rdata = rd; mem_rt_value = rt;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step();
    checks += 4;
    if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", wb_valid); end
    if (RegWrite !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", RegWrite); end
    if (Write_register !== 5'd0) begin failures++; $display("FAIL reset_reg got=%0d exp=0", Write_register); end
    if (Write_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", Write_data); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_loads;
    logic [31:0] exp_d [8];
    logic [2:0]  lt [8];
    logic [1:0]  a [8];
    lt = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd5, 3'd3, 3'd4};
    a  = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1, 2'd3};
    exp_d = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0001, 32'hFFFF_80FF,
              32'h0000_7F01, 32'h80FF_7F01, 32'h0000_7F01, 32'h0000_80FF};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, lt[i], a[i], 32'h80FF_7F01, 32'h0);
      step();
      checks += 3;
      if (RegWrite !== 1'b1) begin failures++; $display("FAIL load%0d_we got=%b exp=1", i, RegWrite); end
      if (Write_register !== 5'd5) begin failures++; $display("FAIL load%0d_reg got=%0d exp=5", i, Write_register); end
      if (Write_data !== exp_d[i]) begin failures++; $display("FAIL load%0d_data got=%h exp=%h", i, Write_data, exp_d[i]); end
    end
  endtask

  task automatic test_lwl_lwr;
    logic [31:0] exp_d [4];
    logic [2:0]  lt [4];
    logic [1:0]  a [4];
    lt = '{3'd6, 3'd7, 3'd6, 3'd7};
    a  = '{2'd1, 2'd2, 2'd0, 2'd3};
    exp_d = '{32'hCCDD_3344, 32'h1122_AABB, 32'hDD22_3344, 32'h1122_33AA};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 5'd9, 32'h0, lt[i], a[i], 32'hAABB_CCDD, 32'h1122_3344);
      step();
      checks++;
      if (Write_data !== exp_d[i]) begin failures++; $display("FAIL merge%0d_data got=%h exp=%h", i, Write_data, exp_d[i]); end
    end
  endtask

  task automatic test_stall;
    drive(1'b1, 1'b1, 5'd7, 32'h1234, 3'd0, 2'd0, 32'h0, 32'h0);
    step();
    checks++;
    if (RegWrite !== 1'b1) begin failures++; $display("FAIL stall_first_we got=%b exp=1", RegWrite); end
    @(negedge clk);
    stall = 1'b1;
    mem_write_reg = 5'd3; mem_alu_result = 32'h5555;
    for (int i = 0; i < 3; i++) begin
      step();
      checks += 3;
      if (RegWrite !== 1'b0) begin failures++; $display("FAIL stall%0d_we got=%b exp=0", i, RegWrite); end
      if (Write_register !== 5'd7) begin failures++; $display("FAIL stall%0d_reg got=%0d exp=7", i, Write_register); end
      if (Write_data !== 32'h1234) begin failures++; $display("FAIL stall%0d_data got=%h exp=1234", i, Write_data); end
    end
    @(negedge clk);
    stall = 1'b0;
    step();
    checks += 2;
    if (RegWrite !== 1'b1 || Write_register !== 5'd3) begin failures++; $display("FAIL unstall_next got we=%b reg=%0d exp we=1 reg=3", RegWrite, Write_register); end
    if (Write_data !== 32'h5555) begin failures++; $display("FAIL unstall_data got=%h exp=5555", Write_data); end
  endtask

  task automatic test_flush;
    drive(1'b1, 1'b1, 5'd4, 32'hABCD, 3'd0, 2'd0, 32'h0, 32'h0);
    @(negedge clk);
    flush = 1'b1; stall = 1'b1;
    step();
    checks += 3;
    if (wb_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", wb_valid); end
    if (RegWrite !== 1'b0) begin failures++; $display("FAIL flush_we got=%b exp=0", RegWrite); end
    if (Write_data !== 32'd0) begin failures++; $display("FAIL flush_data got=%h exp=0", Write_data); end
    @(negedge clk);
    flush = 1'b0;
    step();
    checks++;
    if (wb_valid !== 1'b0 || RegWrite !== 1'b0) begin failures++; $display("FAIL stall_empty got valid=%b we=%b exp 0 0", wb_valid, RegWrite); end
    @(negedge clk);
    stall = 1'b0;
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 1'b1, 5'd10, 32'h1111, 3'd0, 2'd0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 5'd11, 32'h2222, 3'd5, 2'd0, 32'h3333, 32'h0);
    #1;
    checks++;
    if (Write_register !== 5'd10 || Write_data !== 32'h1111 || RegWrite !== 1'b1) begin
      failures++; $display("FAIL b2b_first got reg=%0d data=%h we=%b exp 10 1111 1", Write_register, Write_data, RegWrite);
    end
    drive(1'b0, 1'b1, 5'd12, 32'h4444, 3'd0, 2'd0, 32'h0, 32'h0);
    #1;
    checks++;
    if (Write_register !== 5'd11 || Write_data !== 32'h3333 || RegWrite !== 1'b1) begin
      failures++; $display("FAIL b2b_second got reg=%0d data=%h we=%b exp 11 3333 1", Write_register, Write_data, RegWrite);
    end
    step();
    checks++;
    if (wb_valid !== 1'b0 || RegWrite !== 1'b0 || Write_register !== 5'd0) begin
      failures++; $display("FAIL b2b_bubble got valid=%b we=%b reg=%0d exp 0 0 0", wb_valid, RegWrite, Write_register);
    end
  endtask

  task automatic test_zero_and_async_rst;
    drive(1'b1, 1'b1, 5'd0, 32'h9999, 3'd0, 2'd0, 32'h0, 32'h0);
    step();
    checks += 2;
    if (RegWrite !== 1'b0) begin failures++; $display("FAIL zero_dst_we got=%b exp=0", RegWrite); end
    if (wb_valid !== 1'b1) begin failures++; $display("FAIL zero_dst_valid got=%b exp=1", wb_valid); end
    drive(1'b1, 1'b1, 5'd6, 32'h7777, 3'd0, 2'd0, 32'h0, 32'h0);
    @(negedge clk);
    stall = 1'b1;
    checks++;
    if (RegWrite !== 1'b1) begin failures++; $display("FAIL pre_rst_we got=%b exp=1", RegWrite); end
    #2;
    rst = 1'b1;
    #1;
    checks += 4;
    if (wb_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", wb_valid); end
    if (RegWrite !== 1'b0) begin failures++; $display("FAIL arst_we got=%b exp=0", RegWrite); end
    if (Write_register !== 5'd0) begin failures++; $display("FAIL arst_reg got=%0d exp=0", Write_register); end
    if (Write_data !== 32'd0) begin failures++; $display("FAIL arst_data got=%h exp=0", Write_data); end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if (wb_valid !== 1'b0) begin failures++; $display("FAIL arst_discard got=%b exp=0", wb_valid); end
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_loads();
    test_lwl_lwr();
    test_stall();
    test_flush();
    test_back_to_back();
    test_zero_and_async_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
